regfile_param: RTL and testbench
================================

// Module: regfile_param
// PURPOSE
//  Parametrised CPU register file: DEPTH words of WIDTH bits, one write port with byte enables, two async read ports.
//  Optional hardwired-zero register 0 and a per-register busy scoreboard for pending writes.
//  Sits between decode (read/reserve) and writeback (write/clear) in the single-clock pipeline.
// PARAMETERS
//  WIDTH     32  data bits per register; must be a multiple of 8
//  DEPTH     32  number of registers; must be >= 2
//  ZERO_REG  1   1: register 0 always reads 0, never written, never busy; 0: register 0 is ordinary
//  localparam ADDR_W = $clog2(DEPTH); localparam NBE = WIDTH/8
// PORTS
//  clk           in   1        clock; all state updates on posedge
//  rst_n         in   1        asynchronous, active-low reset
//  wr_en         in   1        write request this cycle
//  wr_addr       in   ADDR_W   write target register
//  wr_be         in   NBE      byte enables; bit i covers wr_data[8i+7:8i]
//  wr_data       in   WIDTH    write data
//  rsv_en        in   1        mark rsv_addr busy (a producer has been issued)
//  rsv_addr      in   ADDR_W   register to reserve
//  rd_addr1/2    in   ADDR_W   read addresses
//  rd_data1/2    out  WIDTH    read data, combinational from rd_addrN
//  rd_busy1/2    out  1        busy flag of rd_addrN, combinational
// BEHAVIOUR
//  Reset (rst_n=0, async): all registers <= 0, all busy bits <= 0; rd_dataN=0 and rd_busyN=0 while held.
//  Write: at posedge with wr_en=1, bytes with wr_be[i]=1 updated, others kept; busy[wr_addr] cleared.
//   wr_en=1 with wr_be=0: no data change, busy still cleared (writeback completion).
//  Reserve: at posedge with rsv_en=1, busy[rsv_addr] <= 1.
//  Same-cycle write+reserve of same addr: data written, busy ends 1 (new producer wins).
//  Out-of-range addr (>= DEPTH, non-power-of-2 DEPTH): write/reserve ignored; read returns 0, busy 0.
//  ZERO_REG=1, addr 0: writes and reserves ignored; rd_data=0, rd_busy=0 always.
//  Read latency 0 (combinational); write visible to reads the cycle after the posedge.
//  Both read ports independent; same address on both returns identical values.
//  Reset asserted mid-operation overrides any write/reserve in that cycle.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: when wr_en=1 and rd_addrN==wr_addr (valid, not zero reg), rd_dataN returns
//   the merged value (new bytes where wr_be=1, stored bytes elsewhere) and rd_busyN reflects post-edge
//   busy (0 unless rsv_en hits the same addr). Combinational path wr_* -> rd_*.
//  Not defined: reads always return stored state; no wr_* -> rd_* combinational path.
// STRUCTURE
//  Package regfile_pkg: default WIDTH/DEPTH constants, byte-lane merge function be_merge(old,new,be).
//  Sub-module regfile_word: one WIDTH-bit register with NBE byte enables, async active-low reset,
//   plus its busy bit; regfile_param instantiates DEPTH of them via generate and muxes reads.
// TESTING
//  1 Reset: write reg5=32'hDEADBEEF, pulse rst_n low mid-cycle -> rd_data1(5)=0 immediately, busy all 0.
//  2 Byte enable: reg3=32'h11223344, write 32'hAABBCCDD be=4'b0101 -> reg3 reads 32'h11BB33DD next cycle.
//  3 Zero reg (ZERO_REG=1): write 32'hFFFFFFFF to reg0, rsv reg0 -> rd_data=0, rd_busy=0; ZERO_REG=0 -> reads FFFFFFFF.
//  4 Scoreboard: rsv reg7 -> busy1=1 next cycle; write reg7 -> busy 0; write+rsv reg7 same cycle -> busy stays 1.
//  5 Bypass: reg9=0, same cycle write 32'h12345678 be=4'hF and rd_addr1=9 -> with REGFILE_BYPASS_EN rd_data1=12345678
//    in that cycle; without it rd_data1=0 then 12345678 after the edge.
//  6 DEPTH=24: write/read addr 30 -> write ignored, rd_data=0; random write/read vs. reference model, 10k cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and helpers for the parametrised register file.
//
//   DEF_WIDTH / DEF_DEPTH : default register width and register count.
//   MERGE_W / MERGE_NBE   : widest register the byte-merge helper handles.
//                           Callers zero-extend into it and truncate back.
//   be_merge(old,new,be)  : byte-lane merge. Lane i comes from new_val when
//                           be[i] is set, otherwise from old_val.
//
//   Optional feature macro used by the top: REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;

    localparam int MERGE_W   = 1024;
    localparam int MERGE_NBE = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] be_merge(
        input logic [MERGE_W-1:0]   old_val,
        input logic [MERGE_W-1:0]   new_val,
        input logic [MERGE_NBE-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_val;
        for (int i = 0; i < MERGE_NBE; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_word.sv
// -----------------------------------------------------------------------------
// regfile_word
//   One WIDTH-bit architectural register with byte enables and its
//   scoreboard busy bit.
//
//   Ports
//     clk      in   1       clock, state updates on posedge
//     rst_n    in   1       asynchronous active-low reset (data and busy -> 0)
//     wr_en    in   1       write strobe, already decoded for this register
//     wr_be    in   NBE     byte enables, bit i covers wr_data[8i+7:8i]
//     wr_data  in   WIDTH   write data
//     rsv_en   in   1       reserve strobe, already decoded for this register
//     q        out  WIDTH   stored value
//     busy     out  1       a producer is outstanding for this register
//
//   WIDTH must be a multiple of 8 and no wider than regfile_pkg::MERGE_W.
// -----------------------------------------------------------------------------
module regfile_word
    import regfile_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int NBE   = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [NBE-1:0]   wr_be,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rsv_en,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    logic [WIDTH-1:0] merged;

    assign merged = WIDTH'(be_merge(MERGE_W'(q), MERGE_W'(wr_data), MERGE_NBE'(wr_be)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            busy <= 1'b0;
        end else begin
            if (wr_en) begin
                q <= merged;
            end
            // A reserve in the same cycle as the completing write belongs to
            // a newer producer, so it takes priority over the clear.
            if (rsv_en) begin
                busy <= 1'b1;
            end else if (wr_en) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
//   Parametrised CPU register file: DEPTH registers of WIDTH bits, one write
//   port with byte enables, two combinational read ports, optional
//   hardwired-zero register 0 and a per-register busy scoreboard.
//
//   Parameters
//     WIDTH     data bits per register (multiple of 8)
//     DEPTH     number of registers (>= 2, need not be a power of two)
//     ZERO_REG  1: register 0 reads 0, is never written and never busy
//
//   Ports
//     clk               in   1       clock
//     rst_n             in   1       asynchronous active-low reset
//     wr_en             in   1       write request
//     wr_addr           in   ADDR_W  write target
//     wr_be             in   NBE     byte enables
//     wr_data           in   WIDTH   write data
//     rsv_en            in   1       mark rsv_addr busy
//     rsv_addr          in   ADDR_W  register to reserve
//     rd_addr1/rd_addr2 in   ADDR_W  read addresses
//     rd_data1/rd_data2 out  WIDTH   read data (combinational)
//     rd_busy1/rd_busy2 out  1       busy flag of the read address
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     When defined, a read that hits the register being written this cycle
//     returns the merged write value and the post-edge busy state. When not
//     defined, reads only see stored state.
// -----------------------------------------------------------------------------
module regfile_param
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int NBE      = WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [NBE-1:0]    wr_be,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [WIDTH-1:0]  rd_data1,
    output logic              rd_busy1,
    output logic [WIDTH-1:0]  rd_data2,
    output logic              rd_busy2
);

    // Every encodable address gets a slot. Slots past DEPTH and the hardwired
    // zero register are tied to 0, so the read mux needs no range check.
    localparam int NSLOT = 1 << ADDR_W;

    logic [WIDTH-1:0] q_arr [NSLOT];
    logic [NSLOT-1:0] busy_vec;

    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        if (i >= DEPTH || (ZERO_REG != 0 && i == 0)) begin : g_tie
            assign q_arr[i]    = '0;
            assign busy_vec[i] = 1'b0;
        end else begin : g_word
            regfile_word #(
                .WIDTH (WIDTH)
            ) u_word (
                .clk     (clk),
                .rst_n   (rst_n),
                .wr_en   (wr_en && (wr_addr == ADDR_W'(i))),
                .wr_be   (wr_be),
                .wr_data (wr_data),
                .rsv_en  (rsv_en && (rsv_addr == ADDR_W'(i))),
                .q       (q_arr[i]),
                .busy    (busy_vec[i])
            );
        end
    end

    logic [WIDTH-1:0] stored1;
    logic [WIDTH-1:0] stored2;
    logic             sbusy1;
    logic             sbusy2;

    assign stored1 = q_arr[rd_addr1];
    assign stored2 = q_arr[rd_addr2];
    assign sbusy1  = busy_vec[rd_addr1];
    assign sbusy2  = busy_vec[rd_addr2];

`ifdef REGFILE_BYPASS_EN
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    // True when the address names a real, writable register.
    function automatic logic slot_valid(input logic [ADDR_W-1:0] a);
        logic ok;
        ok = ({1'b0, a} < DEPTH_L);
        if (ZERO_REG != 0 && a == '0) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    logic             wr_live;
    logic             hit1;
    logic             hit2;
    logic [WIDTH-1:0] fwd1;
    logic [WIDTH-1:0] fwd2;

    // Gating with rst_n keeps the outputs at 0 while reset is held.
    assign wr_live = rst_n && wr_en && slot_valid(wr_addr);
    assign hit1    = wr_live && (rd_addr1 == wr_addr);
    assign hit2    = wr_live && (rd_addr2 == wr_addr);

    assign fwd1 = WIDTH'(be_merge(MERGE_W'(stored1), MERGE_W'(wr_data), MERGE_NBE'(wr_be)));
    assign fwd2 = WIDTH'(be_merge(MERGE_W'(stored2), MERGE_W'(wr_data), MERGE_NBE'(wr_be)));

    // On a hit the write clears busy after the edge unless a new producer
    // reserves the same register in this cycle.
    assign rd_data1 = hit1 ? fwd1 : stored1;
    assign rd_data2 = hit2 ? fwd2 : stored2;
    assign rd_busy1 = hit1 ? (rsv_en && (rsv_addr == rd_addr1)) : sbusy1;
    assign rd_busy2 = hit2 ? (rsv_en && (rsv_addr == rd_addr2)) : sbusy2;
`else
    assign rd_data1 = stored1;
    assign rd_data2 = stored2;
    assign rd_busy1 = sbusy1;
    assign rd_busy2 = sbusy2;
`endif

endmodule

// File: tb/tb_regfile_param.sv
// -----------------------------------------------------------------------------
// tb_regfile_param
//   Directed bench for regfile_param. Three instances share the input bus:
//     u_dut  : WIDTH 32, DEPTH 32, ZERO_REG 1
//     u_nz   : WIDTH 32, DEPTH 32, ZERO_REG 0
//     u_d24  : WIDTH 32, DEPTH 24, ZERO_REG 1
//   Expected values follow REGFILE_BYPASS_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_regfile_param;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;

    logic [31:0] a_d1, a_d2, n_d1, n_d2, c_d1, c_d2;
    logic        a_b1, a_b2, n_b1, n_b2, c_b1, c_b2;

    int checks = 0;
    int errors = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(a_d1), .rd_busy1(a_b1), .rd_data2(a_d2), .rd_busy2(a_b2)
    );

    regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0)) u_nz (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(n_d1), .rd_busy1(n_b1), .rd_data2(n_d2), .rd_busy2(n_b2)
    );

    regfile_param #(.WIDTH(32), .DEPTH(24), .ZERO_REG(1)) u_d24 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(c_d1), .rd_busy1(c_b1), .rd_data2(c_d2), .rd_busy2(c_b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en  = 1'b0;
        wr_be  = 4'h0;
        rsv_en = 1'b0;
    endtask

    task automatic do_wr(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
        tick();
        idle_inputs();
        #1;
    endtask

    task automatic do_rsv(input logic [4:0] a);
        rsv_en = 1'b1; rsv_addr = a;
        tick();
        idle_inputs();
        #1;
    endtask

    // Reference model for the DEPTH=24, ZERO_REG=1 instance.
    logic [31:0] mdata [32];
    logic        mbusy [32];

    function automatic logic [31:0] mmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] be);
        logic [31:0] r;
        r = o;
        if (be[0]) r[7:0]   = n[7:0];
        if (be[1]) r[15:8]  = n[15:8];
        if (be[2]) r[23:16] = n[23:16];
        if (be[3]) r[31:24] = n[31:24];
        return r;
    endfunction

    function automatic logic mvalid(input logic [4:0] a);
        return (a != 5'd0) && (a < 5'd24);
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] a);
        logic [31:0] v;
        v = mvalid(a) ? mdata[a] : 32'h0;
        if (BYP && wr_en && mvalid(a) && wr_addr == a) v = mmerge(v, wr_data, wr_be);
        return v;
    endfunction

    function automatic logic mbusy_rd(input logic [4:0] a);
        logic b;
        b = mvalid(a) ? mbusy[a] : 1'b0;
        if (BYP && wr_en && mvalid(a) && wr_addr == a) b = rsv_en && (rsv_addr == a);
        return b;
    endfunction

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        wr_addr = '0; wr_data = '0; rsv_addr = '0; rd_addr1 = '0; rd_addr2 = '0;

        // Reset state
        rd_addr1 = 5'd5; rd_addr2 = 5'd7;
        #2;
        chk("reset_data", a_d1, 32'h0);
        chk("reset_busy", {31'b0, a_b2}, 32'h0);
        #10;
        rst_n = 1'b1;
        tick();

        // Async reset clears data and busy mid-cycle
        do_wr(5'd5, 4'hF, 32'hDEADBEEF);
        do_rsv(5'd7);
        chk("pre_rst_data", a_d1, 32'hDEADBEEF);
        chk("pre_rst_busy", {31'b0, a_b2}, 32'h1);
        wr_en = 1'b1; wr_addr = 5'd5; wr_be = 4'hF; wr_data = 32'h55555555;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_data", a_d1, 32'h0);
        chk("rst_busy", {31'b0, a_b2}, 32'h0);
        tick();
        chk("rst_hold_data", a_d1, 32'h0);
        idle_inputs();
        rst_n = 1'b1;
        tick();

        // Byte enables
        do_wr(5'd3, 4'hF, 32'h11223344);
        do_wr(5'd3, 4'b0101, 32'hAABBCCDD);
        rd_addr1 = 5'd3; rd_addr2 = 5'd3;
        #1;
        chk("be_merge_p1", a_d1, 32'h11BB33DD);
        chk("be_merge_p2", a_d2, 32'h11BB33DD);

        // Zero register, and ordinary register 0 on the other instance
        rd_addr1 = 5'd0;
        wr_en = 1'b1; wr_addr = 5'd0; wr_be = 4'hF; wr_data = 32'hFFFFFFFF;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        #1;
        chk("zero_inflight", a_d1, 32'h0);
        chk("nz_inflight", n_d1, BYP ? 32'hFFFFFFFF : 32'h0);
        tick();
        idle_inputs();
        #1;
        chk("zero_data", a_d1, 32'h0);
        chk("zero_busy", {31'b0, a_b1}, 32'h0);
        chk("nz_data", n_d1, 32'hFFFFFFFF);
        chk("nz_busy", {31'b0, n_b1}, 32'h1);

        // Scoreboard
        rd_addr1 = 5'd7;
        do_rsv(5'd7);
        chk("sb_rsv", {31'b0, a_b1}, 32'h1);
        do_wr(5'd7, 4'hF, 32'h00000077);
        chk("sb_clr", {31'b0, a_b1}, 32'h0);
        rsv_en = 1'b1; rsv_addr = 5'd7;
        do_wr(5'd7, 4'hF, 32'h00000078);
        chk("sb_wr_rsv_busy", {31'b0, a_b1}, 32'h1);
        chk("sb_wr_rsv_data", a_d1, 32'h00000078);

        // Completion with no bytes enabled
        rd_addr2 = 5'd11;
        do_rsv(5'd11);
        do_wr(5'd11, 4'h0, 32'hFFFFFFFF);
        chk("be0_data", a_d2, 32'h0);
        chk("be0_busy", {31'b0, a_b2}, 32'h0);

        // Bypass of an in-flight write
        rd_addr1 = 5'd9;
        do_rsv(5'd9);
        wr_en = 1'b1; wr_addr = 5'd9; wr_be = 4'hF; wr_data = 32'h12345678;
        #1;
        chk("byp_data", a_d1, BYP ? 32'h12345678 : 32'h0);
        chk("byp_busy", {31'b0, a_b1}, BYP ? 32'h0 : 32'h1);
        tick();
        idle_inputs();
        #1;
        chk("byp_after_data", a_d1, 32'h12345678);
        chk("byp_after_busy", {31'b0, a_b1}, 32'h0);
        wr_en = 1'b1; wr_addr = 5'd9; wr_be = 4'b0011; wr_data = 32'hAABBCCDD;
        #1;
        chk("byp_partial", a_d1, BYP ? 32'h1234CCDD : 32'h12345678);
        tick();
        idle_inputs();
        #1;
        chk("partial_after", a_d1, 32'h1234CCDD);

        // Out-of-range addresses on the DEPTH=24 instance
        rd_addr1 = 5'd30; rd_addr2 = 5'd23;
        rsv_en = 1'b1; rsv_addr = 5'd30;
        do_wr(5'd30, 4'hF, 32'hCAFEF00D);
        chk("oor_data", c_d1, 32'h0);
        chk("oor_busy", {31'b0, c_b1}, 32'h0);
        chk("full_depth_reg30", a_d1, 32'hCAFEF00D);
        do_wr(5'd23, 4'hF, 32'h0BADC0DE);
        chk("last_reg", c_d2, 32'h0BADC0DE);

        // Random traffic against the reference model
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            mdata[i] = 32'h0;
            mbusy[i] = 1'b0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_addr  = 5'($urandom_range(0, 31));
            wr_be    = 4'($urandom_range(0, 15));
            wr_data  = $urandom;
            rsv_en   = ($urandom_range(0, 3) == 0);
            rsv_addr = 5'($urandom_range(0, 31));
            rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rd_addr2 = 5'($urandom_range(0, 31));
            #1;
            chk("rnd_d1", c_d1, mread(rd_addr1));
            chk("rnd_d2", c_d2, mread(rd_addr2));
            chk("rnd_b1", {31'b0, c_b1}, {31'b0, mbusy_rd(rd_addr1)});
            chk("rnd_b2", {31'b0, c_b2}, {31'b0, mbusy_rd(rd_addr2)});
            if (wr_en && mvalid(wr_addr)) begin
                mdata[wr_addr] = mmerge(mdata[wr_addr], wr_data, wr_be);
                mbusy[wr_addr] = 1'b0;
            end
            if (rsv_en && mvalid(rsv_addr)) begin
                mbusy[rsv_addr] = 1'b1;
            end
            tick();
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
